sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares the single on-chip SRAM port (12-bit word address, 16-bit data, two-cycle strobe/hold access) between two requesters.
- Requester 0 is the dirty-bitmap unit; requester 1 is the host data buffer.
- Each request is granted as one sequenced SRAM word access.
- Arbitration is round-robin, with a lock so a requester can issue an uninterrupted multi-word burst (e.g. a 4-word bitmap read-modify-write).

Parameters:
- LOCK_MAX, 8, maximum consecutive locked transactions before the lock is forcibly released (range 1..15).

Ports:
- clk2  in  1  system clock; all state on rising edge
- NReset  in  1  asynchronous, active-low reset
- Req0Read  in  1  requester 0 read request; held until Req0Ack
- Req0Write  in  1  requester 0 write request; held until Req0Ack
- Req0Lock  in  1  requester 0 keeps ownership after the current transaction
- Req0Add  in  12  requester 0 word address; held with the request
- Req0Wdata  in  16  requester 0 write data; held with the request
- Req0Rdata  out  16  read data to requester 0; valid while Req0Ack=1
- Req0Ack  out  1  one-cycle completion pulse to requester 0
- Req1Read, Req1Write, Req1Lock, Req1Add, Req1Wdata, Req1Rdata, Req1Ack: same as requester 0, for requester 1
- Grant  out  2  one-hot current owner; 00 when idle
- SRAMRead  out  1  SRAM read strobe
- SRAMWrite  out  1  SRAM write strobe
- SRAMAdd  out  12  SRAM word address
- SRAMWdata  out  16  SRAM write data
- SRAMRdata  in  16  SRAM read data

Behaviour:
- Reset (async, NReset=0):
  - state=IDLE, owner reg=0, last_served=1 (so requester 0 wins the first tie), lock_active=0, lock_cnt=0, rdata reg=0.
  - All outputs 0; Grant=00.
  - Reset mid-access abandons the access: strobe drops immediately, no Ack.
- States: IDLE -> ACCESS -> HOLD -> ACK -> IDLE.
  - IDLE:
    - Pending_i = ReqiRead | ReqiWrite.
    - If lock_active: only the locked owner is considered; the other requester waits.
    - Otherwise, if exactly one is pending, grant it.
    - If both are pending, grant the requester != last_served.
    - On grant: latch owner, op (write wins if both Read and Write are asserted), address and wdata; go to ACCESS.
  - ACCESS (1 cycle):
    - SRAMRead or SRAMWrite=1 per latched op.
    - SRAMAdd/SRAMWdata driven from the latched values.
  - HOLD (1 cycle):
    - Strobes 0; SRAMAdd/SRAMWdata held.
    - On a read, SRAMRdata is captured into the rdata reg at the end of HOLD.
  - ACK (1 cycle):
    - ReqiAck=1 for the owner only; ReqiRdata=rdata reg (0 for writes).
    - last_served=owner.
    - Lock update: if the owner's ReqiLock=1 and lock_cnt+1 < LOCK_MAX, then lock_active=1 and lock_cnt increments. Otherwise lock_active=0 and lock_cnt=0.
    - Next state IDLE. The requester must drop or change its request in the cycle after Ack.
- Grant: one-hot owner in ACCESS/HOLD/ACK; 00 in IDLE.
- Latency: request seen in IDLE at cycle N -> strobe at N+1 -> Ack at N+3. Minimum 4 cycles per transaction, with IDLE between transactions.
- Lock release:
  - In IDLE with lock_active, if the owner's ReqiLock=0 and it has no request: lock_active=0 and lock_cnt=0, then arbitrate normally in the same cycle.
  - Owner requesting with Lock=0 is granted (last locked beat); the lock is released at that beat's ACK.
  - A forced release at LOCK_MAX hands priority to the other requester via round-robin.
- Outside ACCESS, SRAMRead and SRAMWrite are 0. They are never both 1.
- Request inputs are ignored outside IDLE. Changing Add/Wdata after grant has no effect.
- The non-owner's Ack and Rdata stay 0 throughout.

Test Plan:
- Reset, idle: NReset low then high, no requests -> all outputs 0, Grant=00 for 20 cycles.
- Single read: Req0Read=1, Req0Add=0x0A4 at cycle N; SRAMRdata=0xBEEF during HOLD -> SRAMRead=1 with SRAMAdd=0x0A4 at N+1; Req0Ack=1 with Req0Rdata=0xBEEF at N+3 only.
- Contention round-robin: both requesters hold writes (Add 0x010/0x020) continuously -> SRAM write sequence is 0x010, 0x020, 0x010, 0x020; each Ack is exactly 4 cycles after the prior Ack.
- Locked burst: Req0 does 4 reads (Add 0x100..0x103) with Lock=1 on the first 3 beats while Req1Write is pending -> all 4 Req0 accesses complete before the Req1 access.
- Lock cap: Req0 holds Lock=1 and requests forever, Req1 pending -> Req1 is granted after exactly 8 Req0 transactions.
- Reset mid-access plus simultaneous Read and Write: NReset pulsed during ACCESS -> strobes drop at once, no Ack. After reset, Req1Read and Req1Write both asserted -> SRAMWrite=1 and SRAMRead=0.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one two-cycle strobe/hold SRAM port between the
// dirty-bitmap unit (requester 0) and the host data buffer (requester 1).
module sram_port_arbiter #(
   parameter int unsigned LOCK_MAX = 8
) (
   input  logic        clk2,
   input  logic        NReset,
   input  logic        Req0Read,
   input  logic        Req0Write,
   input  logic        Req0Lock,
   input  logic [11:0] Req0Add,
   input  logic [15:0] Req0Wdata,
   output logic [15:0] Req0Rdata,
   output logic        Req0Ack,
   input  logic        Req1Read,
   input  logic        Req1Write,
   input  logic        Req1Lock,
   input  logic [11:0] Req1Add,
   input  logic [15:0] Req1Wdata,
   output logic [15:0] Req1Rdata,
   output logic        Req1Ack,
   output logic [1:0]  Grant,
   output logic        SRAMRead,
   output logic        SRAMWrite,
   output logic [11:0] SRAMAdd,
   output logic [15:0] SRAMWdata,
   input  logic [15:0] SRAMRdata
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_HOLD, S_ACK} state_e;

   state_e      state_q, state_d;
   logic        owner_q, owner_d;
   logic        last_q, last_d;
   logic        lock_active_q, lock_active_d;
   logic [3:0]  lock_cnt_q, lock_cnt_d;
   logic        op_wr_q, op_wr_d;
   logic [11:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] rdata_q, rdata_d;

   logic pend0, pend1, owner_pend, owner_lock, lock_eff, grant_vld, grant_sel;

   assign pend0      = Req0Read | Req0Write;
   assign pend1      = Req1Read | Req1Write;
   assign owner_pend = owner_q ? pend1 : pend0;
   assign owner_lock = owner_q ? Req1Lock : Req0Lock;

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk2 or negedge NReset) begin
      if (!NReset) begin
         state_q       <= S_IDLE;
         owner_q       <= 1'b0;
         last_q        <= 1'b1;
         lock_active_q <= 1'b0;
         lock_cnt_q    <= 4'd0;
         op_wr_q       <= 1'b0;
         addr_q        <= 12'd0;
         wdata_q       <= 16'd0;
         rdata_q       <= 16'd0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         last_q        <= last_d;
         lock_active_q <= lock_active_d;
         lock_cnt_q    <= lock_cnt_d;
         op_wr_q       <= op_wr_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         rdata_q       <= rdata_d;
      end
   end

   // NOTE: every signal assigned here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      last_d        = last_q;
      lock_active_d = lock_active_q;
      lock_cnt_d    = lock_cnt_q;
      op_wr_d       = op_wr_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      rdata_d       = rdata_q;
      lock_eff      = lock_active_q;
      grant_vld     = 1'b0;
      grant_sel     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            // An idle owner that has dropped Lock gives up ownership this cycle.
            if (lock_active_q && !owner_lock && !owner_pend) begin
               lock_active_d = 1'b0;
               lock_cnt_d    = 4'd0;
               lock_eff      = 1'b0;
            end
            if (lock_eff) begin
               grant_vld = owner_pend;
               grant_sel = owner_q;
            end else if (pend0 && pend1) begin
               grant_vld = 1'b1;
               grant_sel = ~last_q;
            end else if (pend0 || pend1) begin
               grant_vld = 1'b1;
               grant_sel = pend1;
            end
            if (grant_vld) begin
               owner_d = grant_sel;
               op_wr_d = grant_sel ? Req1Write : Req0Write;
               addr_d  = grant_sel ? Req1Add   : Req0Add;
               wdata_d = grant_sel ? Req1Wdata : Req0Wdata;
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: state_d = S_HOLD;
         S_HOLD: begin
            rdata_d = op_wr_q ? 16'd0 : SRAMRdata;
            state_d = S_ACK;
         end
         S_ACK: begin
            last_d = owner_q;
            if (owner_lock && ((5'(lock_cnt_q) + 5'd1) < 5'(LOCK_MAX))) begin
               lock_active_d = 1'b1;
               lock_cnt_d    = lock_cnt_q + 4'd1;
            end else begin
               lock_active_d = 1'b0;
               lock_cnt_d    = 4'd0;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      Grant     = (state_q == S_IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
      SRAMRead  = (state_q == S_ACCESS) && !op_wr_q;
      SRAMWrite = (state_q == S_ACCESS) && op_wr_q;
      SRAMAdd   = 12'd0;
      SRAMWdata = 16'd0;
      if (state_q == S_ACCESS || state_q == S_HOLD) begin
         SRAMAdd   = addr_q;
         SRAMWdata = wdata_q;
      end
      Req0Ack   = (state_q == S_ACK) && !owner_q;
      Req1Ack   = (state_q == S_ACK) && owner_q;
      Req0Rdata = Req0Ack ? rdata_q : 16'd0;
      Req1Rdata = Req1Ack ? rdata_q : 16'd0;
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: reset, single read, round-robin,
// locked burst, lock cap, and reset during an access.
module tb_sram_port_arbiter;

   logic        clk2 = 1'b0;
   logic        NReset;
   logic        Req0Read, Req0Write, Req0Lock;
   logic [11:0] Req0Add;
   logic [15:0] Req0Wdata, Req0Rdata;
   logic        Req0Ack;
   logic        Req1Read, Req1Write, Req1Lock;
   logic [11:0] Req1Add;
   logic [15:0] Req1Wdata, Req1Rdata;
   logic        Req1Ack;
   logic [1:0]  Grant;
   logic        SRAMRead, SRAMWrite;
   logic [11:0] SRAMAdd;
   logic [15:0] SRAMWdata, SRAMRdata;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   sram_port_arbiter #(.LOCK_MAX(8)) dut (
      .clk2(clk2), .NReset(NReset),
      .Req0Read(Req0Read), .Req0Write(Req0Write), .Req0Lock(Req0Lock),
      .Req0Add(Req0Add), .Req0Wdata(Req0Wdata), .Req0Rdata(Req0Rdata), .Req0Ack(Req0Ack),
      .Req1Read(Req1Read), .Req1Write(Req1Write), .Req1Lock(Req1Lock),
      .Req1Add(Req1Add), .Req1Wdata(Req1Wdata), .Req1Rdata(Req1Rdata), .Req1Ack(Req1Ack),
      .Grant(Grant), .SRAMRead(SRAMRead), .SRAMWrite(SRAMWrite),
      .SRAMAdd(SRAMAdd), .SRAMWdata(SRAMWdata), .SRAMRdata(SRAMRdata)
   );

   always #5 clk2 = ~clk2;

   task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [79:0] all_outs();
      return {Grant, SRAMRead, SRAMWrite, SRAMAdd, SRAMWdata,
              Req0Ack, Req0Rdata, Req1Ack, Req1Rdata};
   endfunction

   task automatic tick();
      @(posedge clk2);
      #1;
      cyc++;
   endtask

   task automatic clear_inputs();
      Req0Read = 0; Req0Write = 0; Req0Lock = 0; Req0Add = '0; Req0Wdata = '0;
      Req1Read = 0; Req1Write = 0; Req1Lock = 0; Req1Add = '0; Req1Wdata = '0;
      SRAMRdata = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      NReset = 1'b0;
      tick();
      tick();
      check("reset_outs", all_outs(), 80'd0);
      NReset = 1'b1;
   endtask

   task automatic wait_strobe(input string tag, input int budget);
      bit seen = 0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (SRAMRead || SRAMWrite) begin
            seen = 1;
            break;
         end
      end
      check({tag, "_strobe_seen"}, 80'(seen), 80'd1);
   endtask

   task automatic wait_any_ack(input string tag, input int budget);
      bit seen = 0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (Req0Ack || Req1Ack) begin
            seen = 1;
            break;
         end
      end
      check({tag, "_ack_seen"}, 80'(seen), 80'd1);
   endtask

   initial begin
      int t0, prev_ack, n0;
      bit seen, any_ack;
      logic [11:0] exp_add;

      NReset = 1'b0;
      clear_inputs();

      // Reset and idle for 20 cycles.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         tick();
         check($sformatf("idle_c%0d", i), all_outs(), 80'd0);
      end

      // Single read from requester 0.
      do_reset();
      tick();
      Req0Read = 1; Req0Add = 12'h0A4;
      tick();
      check("rd_access_strobe", {SRAMRead, SRAMWrite}, 2'b10);
      check("rd_access_add", SRAMAdd, 12'h0A4);
      check("rd_access_grant", Grant, 2'b01);
      check("rd_access_noack", {Req0Ack, Req1Ack}, 2'b00);
      SRAMRdata = 16'hBEEF;
      tick();
      check("rd_hold_strobe", {SRAMRead, SRAMWrite}, 2'b00);
      check("rd_hold_add", SRAMAdd, 12'h0A4);
      check("rd_hold_noack", {Req0Ack, Req1Ack}, 2'b00);
      tick();
      SRAMRdata = 16'h0000;
      check("rd_ack", {Req1Ack, Req0Ack}, 2'b01);
      check("rd_rdata", Req0Rdata, 16'hBEEF);
      check("rd_other_rdata", Req1Rdata, 16'h0000);
      Req0Read = 0;
      tick();
      check("rd_after_ack", {Grant, Req0Ack}, 3'b000);

      // Round-robin with both requesters writing continuously.
      do_reset();
      tick();
      Req0Write = 1; Req0Add = 12'h010; Req0Wdata = 16'h1111;
      Req1Write = 1; Req1Add = 12'h020; Req1Wdata = 16'h2222;
      t0 = cyc;
      prev_ack = 0;
      for (int k = 0; k < 4; k++) begin
         wait_strobe($sformatf("rr%0d", k), 8);
         check($sformatf("rr%0d_add", k), SRAMAdd, (k % 2 == 0) ? 12'h010 : 12'h020);
         check($sformatf("rr%0d_wdata", k), SRAMWdata, (k % 2 == 0) ? 16'h1111 : 16'h2222);
         check($sformatf("rr%0d_wr", k), {SRAMRead, SRAMWrite}, 2'b01);
         wait_any_ack($sformatf("rr%0d", k), 4);
         check($sformatf("rr%0d_who", k), {Req1Ack, Req0Ack}, (k % 2 == 0) ? 2'b01 : 2'b10);
         if (k == 0) check("rr0_latency", 80'(cyc - t0), 80'd3);
         else        check($sformatf("rr%0d_spacing", k), 80'(cyc - prev_ack), 80'd4);
         prev_ack = cyc;
      end
      clear_inputs();

      // Locked 4-beat burst by requester 0 while requester 1 waits.
      do_reset();
      tick();
      Req1Write = 1; Req1Add = 12'h333; Req1Wdata = 16'h3333;
      for (int b = 0; b < 4; b++) begin
         Req0Read = 1; Req0Add = 12'h100 + 12'(b); Req0Lock = (b < 3);
         wait_strobe($sformatf("burst%0d", b), 8);
         exp_add = 12'h100 + 12'(b);
         check($sformatf("burst%0d_add", b), SRAMAdd, exp_add);
         check($sformatf("burst%0d_grant", b), Grant, 2'b01);
         wait_any_ack($sformatf("burst%0d", b), 4);
         check($sformatf("burst%0d_who", b), {Req1Ack, Req0Ack}, 2'b01);
         tick();
      end
      Req0Read = 0; Req0Lock = 0;
      wait_strobe("burst_r1", 8);
      check("burst_r1_add", SRAMAdd, 12'h333);
      check("burst_r1_grant", Grant, 2'b10);
      clear_inputs();

      // Lock cap: requester 0 locks forever, requester 1 pending.
      do_reset();
      tick();
      Req0Read = 1; Req0Lock = 1; Req0Add = 12'h200;
      Req1Write = 1; Req1Add = 12'h444;
      n0 = 0;
      seen = 0;
      for (int i = 0; i < 120; i++) begin
         tick();
         if (SRAMRead && Grant == 2'b01) n0++;
         if (SRAMWrite && Grant == 2'b10) begin
            seen = 1;
            break;
         end
      end
      check("cap_r1_granted", 80'(seen), 80'd1);
      check("cap_r0_count", 80'(n0), 80'd8);
      check("cap_r1_add", SRAMAdd, 12'h444);
      clear_inputs();

      // Reset during ACCESS abandons the access.
      do_reset();
      tick();
      Req0Write = 1; Req0Add = 12'h055; Req0Wdata = 16'h5555;
      tick();
      check("mid_access_strobe", {SRAMRead, SRAMWrite}, 2'b01);
      NReset = 1'b0;
      #1;
      check("mid_reset_outs", all_outs(), 80'd0);
      Req0Write = 0;
      tick();
      tick();
      NReset = 1'b1;
      any_ack = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (Req0Ack || Req1Ack) any_ack = 1;
      end
      check("mid_no_ack", 80'(any_ack), 80'd0);

      // Simultaneous read and write: write wins.
      Req1Read = 1; Req1Write = 1; Req1Add = 12'h077; Req1Wdata = 16'h7777;
      tick();
      check("rw_strobe", {SRAMRead, SRAMWrite}, 2'b01);
      check("rw_grant", Grant, 2'b10);
      check("rw_add", SRAMAdd, 12'h077);
      SRAMRdata = 16'hDEAD;
      tick();
      tick();
      check("rw_ack", {Req1Ack, Req0Ack}, 2'b10);
      check("rw_rdata_zero", Req1Rdata, 16'h0000);
      clear_inputs();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
